// File: rtl/counter_cmd_ctrl.sv
// Command sequencer for the 10 Hz counter: merges UART command bytes and button pulses into run/mode/clear,
// and streams a 4-digit decimal status report plus CR LF. Define COUNTER_CTRL_ECHO_EN to echo every popped byte.
module counter_cmd_ctrl #(
    parameter int         CNT_W     = 14,
    parameter logic [7:0] CMD_RUN   = 8'h52,
    parameter logic [7:0] CMD_CLEAR = 8'h43,
    parameter logic [7:0] CMD_MODE  = 8'h4D,
    parameter logic [7:0] CMD_STAT  = 8'h53
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rx_pop,
    input  logic             tx_full,
    output logic             tx_push,
    output logic [7:0]       tx_data,
    input  logic             btn_run,
    input  logic             btn_clear,
    input  logic             btn_mode,
    input  logic [CNT_W-1:0] counter,
    output logic             run,
    output logic             mode,
    output logic             clear,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ECHO = 2'd1, DECODE = 2'd2, SEND = 2'd3} state_t;

    state_t           state;
    logic [7:0]       cmd;
    logic [2:0]       slot;
    logic [CNT_W-1:0] snap;
    logic [7:0]       slot_byte;
    logic             pop_now, send_go, uart_clr, dec_run, dec_mode, dec_stat;

    // Letters only: bit 5 selects lower case, so forcing it folds both cases together.
    function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] c);
        return (b | 8'h20) == (c | 8'h20);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(9999)) ? CNT_W'(9999) : v;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [CNT_W-1:0] v, input int unsigned div);
        logic [31:0] q;
        q = (32'(v) / div) % 32'd10;
        return 8'h30 + q[7:0];
    endfunction

    always_comb begin
        slot_byte = 8'h00;
        case (slot)
            3'd0:    slot_byte = ascii_digit(snap, 1000);
            3'd1:    slot_byte = ascii_digit(snap, 100);
            3'd2:    slot_byte = ascii_digit(snap, 10);
            3'd3:    slot_byte = ascii_digit(snap, 1);
            3'd4:    slot_byte = 8'h0D;
            3'd5:    slot_byte = 8'h0A;
            default: slot_byte = 8'h00;
        endcase
    end

    assign pop_now  = (state == IDLE) && !rx_empty && !rst;
    assign send_go  = (state == SEND) && !tx_full;
    assign dec_run  = (state == DECODE) && is_cmd(cmd, CMD_RUN);
    assign dec_mode = (state == DECODE) && is_cmd(cmd, CMD_MODE);
    assign dec_stat = (state == DECODE) && is_cmd(cmd, CMD_STAT);
    assign rx_pop   = pop_now;
    assign busy     = (state != IDLE);

`ifdef COUNTER_CTRL_ECHO_EN
    logic echo_go;
    assign echo_go  = (state == ECHO) && !tx_full;
    // Clear is issued on the echo push edge so the pulse lands in the DECODE cycle.
    assign uart_clr = echo_go && is_cmd(cmd, CMD_CLEAR);
    assign tx_push  = send_go | echo_go;
    assign tx_data  = (state == ECHO) ? cmd : ((state == SEND) ? slot_byte : 8'h00);
`else
    // Clear is issued on the pop edge so the pulse lands in the DECODE cycle.
    assign uart_clr = pop_now && is_cmd(rx_data, CMD_CLEAR);
    assign tx_push  = send_go;
    assign tx_data  = (state == SEND) ? slot_byte : 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= 8'h00;
            slot  <= 3'd0;
            run   <= 1'b0;
            mode  <= 1'b0;
            clear <= 1'b0;
        end else begin
            // Button and UART requests are OR-ed so a coincident pair yields one action.
            run   <= run ^ (btn_run | dec_run);
            mode  <= mode ^ (btn_mode | dec_mode);
            clear <= btn_clear | uart_clr;
            case (state)
                IDLE: begin
                    if (pop_now) begin
                        cmd <= rx_data;
`ifdef COUNTER_CTRL_ECHO_EN
                        state <= ECHO;
`else
                        state <= DECODE;
`endif
                    end
                end
`ifdef COUNTER_CTRL_ECHO_EN
                ECHO: begin
                    if (!tx_full) state <= DECODE;
                end
`endif
                DECODE: begin
                    slot  <= 3'd0;
                    state <= dec_stat ? SEND : IDLE;
                end
                SEND: begin
                    if (!tx_full) begin
                        if (slot == 3'd5) state <= IDLE;
                        else slot <= slot + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot is pure data; it is only read in SEND, which always follows a load.
    always_ff @(posedge clk) begin
        if (dec_stat) snap <= sat_cnt(counter);
    end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl; follows COUNTER_CTRL_ECHO_EN when the macro is defined.
module tb_counter_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst, rx_empty, rx_pop, tx_full, tx_push;
    logic        btn_run, btn_clear, btn_mode, run, mode, clear, busy;
    logic [7:0]  rx_data, tx_data;
    logic [13:0] counter;
    int          tests = 0;
    int          fails = 0;
    logic        exp_run = 1'b0;
    logic        exp_mode = 1'b0;

    always #5 clk = ~clk;

    counter_cmd_ctrl dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .counter(counter), .run(run), .mode(mode), .clear(clear), .busy(busy)
    );

    task automatic go();
        @(posedge clk);
        #3;
    endtask

    // Presents a byte in an IDLE cycle, expects the pop there, then empties the FIFO.
    task automatic pop_byte(input logic [7:0] b);
        rx_data = b; rx_empty = 1'b0; #1;
        tests++; if (rx_pop !== 1'b1) begin fails++; $display("FAIL pop_%h rx_pop=%b want 1", b, rx_pop); end
        go();
        rx_empty = 1'b1; #1;
        tests++; if (rx_pop !== 1'b0) begin fails++; $display("FAIL pop_once_%h rx_pop=%b want 0", b, rx_pop); end
    endtask

    // Cycle after the pop: echo push (echo build) or the DECODE cycle with no TX traffic.
    task automatic echo_step(input logic [7:0] b);
`ifdef COUNTER_CTRL_ECHO_EN
        tests++; if (tx_push !== 1'b1 || tx_data !== b) begin
            fails++; $display("FAIL echo_%h push=%b data=%h want 1/%h", b, tx_push, tx_data, b); end
        go();
`else
        tests++; if (tx_push !== 1'b0) begin fails++; $display("FAIL no_echo_%h push=%b want 0", b, tx_push); end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_empty = 1'b1; rx_data = 8'h00; tx_full = 1'b0; counter = 14'd0;
        btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0; #1;
        tests++; if (run !== 1'b0) begin fails++; $display("FAIL rst_run got %b want 0", run); end
        tests++; if (mode !== 1'b0) begin fails++; $display("FAIL rst_mode got %b want 0", mode); end
        tests++; if (clear !== 1'b0) begin fails++; $display("FAIL rst_clear got %b want 0", clear); end
        tests++; if (tx_push !== 1'b0) begin fails++; $display("FAIL rst_tx_push got %b want 0", tx_push); end
        tests++; if (rx_pop !== 1'b0) begin fails++; $display("FAIL rst_rx_pop got %b want 0", rx_pop); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    endtask

    task automatic test_run_toggle();
        go();
        pop_byte("R"); echo_step("R");
        tests++; if (run !== exp_run) begin fails++; $display("FAIL run_decode got %b want %b", run, exp_run); end
        go(); exp_run = ~exp_run;
        tests++; if (run !== exp_run) begin fails++; $display("FAIL run_R got %b want %b", run, exp_run); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL run_idle busy=%b want 0", busy); end
        pop_byte("r"); echo_step("r"); go(); exp_run = ~exp_run;
        tests++; if (run !== exp_run) begin fails++; $display("FAIL run_r got %b want %b", run, exp_run); end
    endtask

    task automatic test_clear();
        go();
        btn_run = 1'b1; btn_mode = 1'b1; go(); btn_run = 1'b0; btn_mode = 1'b0;
        exp_run = ~exp_run; exp_mode = ~exp_mode;
        tests++; if (run !== exp_run || mode !== exp_mode) begin
            fails++; $display("FAIL btn_toggle run/mode=%b%b want %b%b", run, mode, exp_run, exp_mode); end
        pop_byte("C"); echo_step("C");
        tests++; if (clear !== 1'b1) begin fails++; $display("FAIL clear_C got %b want 1", clear); end
        go();
        tests++; if (clear !== 1'b0) begin fails++; $display("FAIL clear_C_width got %b want 0", clear); end
        tests++; if (run !== exp_run || mode !== exp_mode) begin
            fails++; $display("FAIL clear_keeps run/mode=%b%b want %b%b", run, mode, exp_run, exp_mode); end
        btn_clear = 1'b1; go(); btn_clear = 1'b0; #1;
        tests++; if (clear !== 1'b1) begin fails++; $display("FAIL clear_btn got %b want 1", clear); end
        go();
        tests++; if (clear !== 1'b0) begin fails++; $display("FAIL clear_btn_width got %b want 0", clear); end
        pop_byte("x"); echo_step("x");
        tests++; if (clear !== 1'b0) begin fails++; $display("FAIL unknown_clear got %b want 0", clear); end
        go();
        tests++; if (run !== exp_run || mode !== exp_mode || busy !== 1'b0) begin
            fails++; $display("FAIL unknown_x run/mode/busy=%b%b%b want %b%b0", run, mode, busy, exp_run, exp_mode); end
    endtask

    task automatic test_mode_merge();
        go();
        if (exp_mode) begin btn_mode = 1'b1; go(); btn_mode = 1'b0; exp_mode = 1'b0; end
        go();
        pop_byte("M"); echo_step("M");
        btn_mode = 1'b1; go(); btn_mode = 1'b0; exp_mode = 1'b1; #1;
        tests++; if (mode !== exp_mode) begin fails++; $display("FAIL mode_merge got %b want %b", mode, exp_mode); end
        go();
        tests++; if (mode !== exp_mode) begin fails++; $display("FAIL mode_single got %b want %b", mode, exp_mode); end
    endtask

    // Runs one status report; stall_slot holds tx_full for 3 cycles, btn_slot pulses btn_run there.
    task automatic report(input logic [13:0] cnt, input logic [31:0] digits, input int stall_slot, input int btn_slot);
        logic [7:0] exp;
        go();
        counter = cnt; tx_full = 1'b0;
        pop_byte("S"); echo_step("S");
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rpt_busy got %b want 1", busy); end
        go();
        counter = 14'd9000;
        for (int i = 0; i < 6; i++) begin
            exp = (i < 4) ? digits[31-8*i -: 8] : ((i == 4) ? 8'h0D : 8'h0A);
            if (i == stall_slot) begin
                tx_full = 1'b1; #1;
                for (int k = 0; k < 3; k++) begin
                    tests++; if (tx_push !== 1'b0 || tx_data !== exp) begin
                        fails++; $display("FAIL rpt_stall%0d push=%b data=%h want 0/%h", k, tx_push, tx_data, exp); end
                    go();
                end
                tx_full = 1'b0;
            end
            if (i == btn_slot) btn_run = 1'b1;
            #1;
            tests++; if (tx_push !== 1'b1 || tx_data !== exp) begin
                fails++; $display("FAIL rpt_slot%0d push=%b data=%h want 1/%h", i, tx_push, tx_data, exp); end
            go();
            btn_run = 1'b0;
            if (i == btn_slot) begin
                exp_run = ~exp_run;
                tests++; if (run !== exp_run) begin fails++; $display("FAIL rpt_btn_run got %b want %b", run, exp_run); end
            end
        end
        #1;
        tests++; if (tx_push !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rpt_end push=%b busy=%b want 0/0", tx_push, busy); end
    endtask

    task automatic test_cmd_m_tx();
        go();
        pop_byte("M"); echo_step("M");
        tests++; if (mode !== exp_mode || tx_push !== 1'b0) begin
            fails++; $display("FAIL m_decode mode=%b push=%b want %b/0", mode, tx_push, exp_mode); end
        go(); exp_mode = ~exp_mode;
        tests++; if (mode !== exp_mode || tx_push !== 1'b0) begin
            fails++; $display("FAIL m_after mode=%b push=%b want %b/0", mode, tx_push, exp_mode); end
    endtask

    task automatic test_reset_mid();
        go();
        counter = 14'd407; tx_full = 1'b1;
        pop_byte("S"); go(); go();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", busy); end
        btn_run = 1'b1; btn_mode = 1'b1; btn_clear = 1'b1; go();
        btn_run = 1'b0; btn_mode = 1'b0; btn_clear = 1'b0;
        exp_run = ~exp_run; exp_mode = ~exp_mode;
        tests++; if (run !== exp_run || mode !== exp_mode || clear !== 1'b1) begin
            fails++; $display("FAIL mid_pre run/mode/clear=%b%b%b want %b%b1", run, mode, clear, exp_run, exp_mode); end
        rx_data = "Q"; rx_empty = 1'b0;
        #2 rst = 1'b1; tx_full = 1'b0; #1;
        exp_run = 1'b0; exp_mode = 1'b0;
        tests++; if (run !== 1'b0 || mode !== 1'b0 || clear !== 1'b0) begin
            fails++; $display("FAIL mid_rst run/mode/clear=%b%b%b want 000", run, mode, clear); end
        tests++; if (tx_push !== 1'b0 || rx_pop !== 1'b0) begin
            fails++; $display("FAIL mid_rst push/pop=%b%b want 00", tx_push, rx_pop); end
        rx_empty = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            go();
            tests++; if (tx_push !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL mid_after%0d push=%b busy=%b want 0/0", i, tx_push, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_run_toggle();
        test_clear();
        test_mode_merge();
        report(14'd407, "0407", -1, 2);
        report(14'd407, "0407", 2, -1);
        report(14'd12345, "9999", -1, -1);
        report(14'd5168, "5168", 4, 0);
        test_cmd_m_tx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
